// File: rtl/vwiden_pkg.sv
// Shared types and helpers for the vector widening unit.
package vwiden_pkg;

    typedef enum logic [1:0] {SEW8, SEW16, SEW32, SEW64} sew_e;
    typedef enum logic [1:0] {FACTOR_1, FACTOR_2, FACTOR_4, FACTOR_8} factor_e;
    typedef enum logic {IDLE, EMIT} state_e;

    localparam int MAX_BEATS = 8;
    localparam int BEAT_W    = $clog2(MAX_BEATS);

    // Destination beats produced per source beat for a log2 widening factor.
    function automatic logic [3:0] beats(input logic [1:0] factor);
        return 4'd1 << factor;
    endfunction

endpackage

// File: rtl/vwiden_seq_if.sv
// Source/destination valid-ready bundle of the widening unit.
interface vwiden_seq_if #(
    parameter int DATA_WIDTH = 64,
    parameter int SEW_WIDTH  = 2,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_vec0;
    logic [DATA_WIDTH-1:0] in_vec1;
    logic [BE_WIDTH-1:0]   in_be;
    logic [SEW_WIDTH-1:0]  in_sew;
    logic [1:0]            in_factor;
    logic                  in_signed0;
    logic                  in_signed1;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_vec0;
    logic [DATA_WIDTH-1:0] out_vec1;
    logic [BE_WIDTH-1:0]   out_be;
    logic [SEW_WIDTH-1:0]  out_sew;
    logic [2:0]            out_beat;
    logic                  out_last;
    logic                  out_err;

    modport slave (
        input  in_valid, in_vec0, in_vec1, in_be, in_sew, in_factor,
               in_signed0, in_signed1, out_ready,
        output in_ready, out_valid, out_vec0, out_vec1, out_be, out_sew,
               out_beat, out_last, out_err
    );

    modport master (
        output in_valid, in_vec0, in_vec1, in_be, in_sew, in_factor,
               in_signed0, in_signed1, out_ready,
        input  in_ready, out_valid, out_vec0, out_vec1, out_be, out_sew,
               out_beat, out_last, out_err
    );
endinterface

// File: rtl/vwiden_ext.sv
// Combinational element extender: source elements sit in the low bits of src,
// each is sign/zero-extended to (8 << sew) << factor bits.
module vwiden_ext
    import vwiden_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] src,
    input  sew_e                  sew,
    input  factor_e               factor,
    input  logic                  signed_en,
    output logic [DATA_WIDTH-1:0] dst
);

    logic [3:0] w_log;
    logic [3:0] ow_log;

    assign w_log  = 4'd3 + {2'b00, sew};
    assign ow_log = w_log + {2'b00, factor};

    // Output bit i belongs to element i >> ow_log; bits above the source width
    // copy the element's top bit when signed, else read zero.
    function automatic logic ext_bit(input int i, input logic [DATA_WIDTH-1:0] s,
                                     input int wl, input int owl, input logic sg);
        int k;
        int p;
        int w;
        k = i >> owl;
        p = i & ((1 << owl) - 1);
        w = 1 << wl;
        if (p < w)
            return 1'(s >> (k * w + p));
        return sg & 1'(s >> (k * w + w - 1));
    endfunction

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
            assign dst[gi] = ext_bit(gi, src, int'(w_log), int'(ow_log), signed_en);
        end
    endgenerate

endmodule

// File: rtl/vwiden_seq.sv
// Sequenced widening unit: captures one source beat, then emits 1/2/4/8
// widened destination beats from the held copy.
module vwiden_seq
    import vwiden_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int SEW_WIDTH  = 2,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic         clk,
    input  logic         rst_n,
    vwiden_seq_if.slave  bus
);

    state_e                state_reg;
    logic [BEAT_W-1:0]     beat_reg;
    logic [DATA_WIDTH-1:0] vec0_reg;
    logic [DATA_WIDTH-1:0] vec1_reg;
    logic [BE_WIDTH-1:0]   be_reg;
    sew_e                  sew_reg;
    factor_e               factor_reg;
    logic                  signed0_reg;
    logic                  signed1_reg;
    logic                  err_reg;

    logic                  out_valid_int;
    logic                  in_ready_int;
    logic                  last_beat;
    logic                  out_fire;
    logic                  in_fire;
    logic                  in_err;
    logic [1:0]            sew_bits;
    logic [1:0]            factor_bits;
    int                    data_shamt;
    int                    be_shamt;
    logic [DATA_WIDTH-1:0] slice0;
    logic [DATA_WIDTH-1:0] slice1;
    logic [DATA_WIDTH-1:0] ext0;
    logic [DATA_WIDTH-1:0] ext1;
    logic [BE_WIDTH-1:0]   be_slice;
    logic [BE_WIDTH-1:0]   be_wide;

    assign sew_bits      = sew_reg;
    assign factor_bits   = factor_reg;
    assign out_valid_int = (state_reg == EMIT);
    assign last_beat     = (beat_reg == BEAT_W'(beats(factor_bits) - 4'd1));
    assign out_fire      = out_valid_int & bus.out_ready;
    assign in_ready_int  = (state_reg == IDLE) | (out_fire & last_beat);
    assign in_fire       = bus.in_valid & in_ready_int;
    assign in_err        = ({1'b0, bus.in_sew} + {1'b0, bus.in_factor}) > 3'd3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            beat_reg    <= '0;
            vec0_reg    <= '0;
            vec1_reg    <= '0;
            be_reg      <= '0;
            sew_reg     <= SEW8;
            factor_reg  <= FACTOR_1;
            signed0_reg <= 1'b0;
            signed1_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else if (in_fire) begin
            // Also covers the last-beat handshake overlapping a new source beat.
            state_reg   <= EMIT;
            beat_reg    <= '0;
            vec0_reg    <= bus.in_vec0;
            vec1_reg    <= bus.in_vec1;
            be_reg      <= bus.in_be;
            sew_reg     <= sew_e'(bus.in_sew);
            factor_reg  <= factor_e'(bus.in_factor);
            signed0_reg <= bus.in_signed0;
            signed1_reg <= bus.in_signed1;
            err_reg     <= in_err;
        end else if (out_fire) begin
            if (last_beat) begin
                state_reg <= IDLE;
                beat_reg  <= '0;
            end else begin
                beat_reg  <= beat_reg + 1'b1;
            end
        end
    end

    // Bring the current beat's source slice down to bit 0.
    assign data_shamt = (int'(beat_reg) * DATA_WIDTH) >> factor_bits;
    assign be_shamt   = (int'(beat_reg) * BE_WIDTH) >> factor_bits;
    assign slice0     = vec0_reg >> data_shamt;
    assign slice1     = vec1_reg >> data_shamt;
    assign be_slice   = be_reg >> be_shamt;

    vwiden_ext #(.DATA_WIDTH(DATA_WIDTH)) u_ext0 (
        .src(slice0), .sew(sew_reg), .factor(factor_reg), .signed_en(signed0_reg), .dst(ext0)
    );

    vwiden_ext #(.DATA_WIDTH(DATA_WIDTH)) u_ext1 (
        .src(slice1), .sew(sew_reg), .factor(factor_reg), .signed_en(signed1_reg), .dst(ext1)
    );

    generate
        for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_be
            assign be_wide[gi] = 1'(be_slice >> (gi >> factor_bits));
        end
    endgenerate

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_beat  = 3'(beat_reg);
    assign bus.out_last  = last_beat & out_valid_int;
    assign bus.out_err   = err_reg & out_valid_int;
    assign bus.out_sew   = out_valid_int ? SEW_WIDTH'(sew_bits + factor_bits) : '0;
    assign bus.out_vec0  = (out_valid_int & ~err_reg) ? ext0 : '0;
    assign bus.out_vec1  = (out_valid_int & ~err_reg) ? ext1 : '0;
    assign bus.out_be    = (out_valid_int & ~err_reg) ? be_wide : '0;

endmodule

// File: tb/tb_vwiden_seq.sv
// Directed self-checking bench for vwiden_seq.
module tb_vwiden_seq;

    typedef logic [143:0] snap_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    vwiden_seq_if #(.DATA_WIDTH(64), .SEW_WIDTH(2), .BE_WIDTH(8)) bus ();

    vwiden_seq #(.DATA_WIDTH(64), .SEW_WIDTH(2), .BE_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // {valid, beat, last, err, sew, be, vec0, vec1}
    function automatic snap_t snap();
        return {bus.out_valid, bus.out_beat, bus.out_last, bus.out_err, bus.out_sew,
                bus.out_be, bus.out_vec0, bus.out_vec1};
    endfunction

    // Called at a negedge; returns at the negedge after the input handshake.
    task automatic send(input logic [63:0] v0, input logic [63:0] v1, input logic [7:0] be,
                        input logic [1:0] sew, input logic [1:0] fac, input logic s0, input logic s1);
        int n;
        bus.in_vec0 = v0; bus.in_vec1 = v1; bus.in_be = be; bus.in_sew = sew;
        bus.in_factor = fac; bus.in_signed0 = s0; bus.in_signed1 = s1; bus.in_valid = 1'b1;
        n = 0;
        #1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL send_timeout got=in_ready_low want=in_ready_high");
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (snap() !== '0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_hold got=%h/%b want=0/1", snap(), bus.in_ready);
        end else $display("reset_hold ok");
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (snap() !== '0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release got=%h/%b want=0/1", snap(), bus.in_ready);
        end else $display("reset_release ok");
    endtask

    task automatic test_x2();
        logic [63:0] e0 [2];
        logic [63:0] e1 [2];
        logic [7:0]  eb [2];
        snap_t want;
        e0 = '{64'h0000_FFFF_007F_FF80, 64'hFF88_FF99_FFAA_FFBB};
        e1 = '{64'h0000_00FF_007F_0080, 64'h0088_0099_00AA_00BB};
        eb = '{8'h33, 8'h00};
        bus.out_ready = 1'b1;
        send(64'h8899AABB_00FF7F80, 64'h8899AABB_00FF7F80, 8'h05, 2'd0, 2'd1, 1'b1, 1'b0);
        for (int b = 0; b < 2; b++) begin
            want = {1'b1, 3'(b), b == 1, 1'b0, 2'd1, eb[b], e0[b], e1[b]};
            total++;
            if (snap() !== want) begin
                bad++; $display("FAIL x2_beat%0d got=%h want=%h", b, snap(), want);
            end else $display("x2 beat%0d ok", b);
            @(negedge clk);
        end
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL x2_idle got=%b/%b want=0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_x4();
        logic [63:0] e0 [4];
        logic [63:0] e1 [4];
        logic [7:0]  eb [4];
        snap_t want;
        e0 = '{64'h0, 64'h0, 64'h0, 64'hFFFFFFFF_FFFFFF80};
        e1 = '{64'h00000007_00000008, 64'h00000005_00000006,
               64'h00000003_00000004, 64'h00000001_00000002};
        eb = '{8'hF0, 8'h0F, 8'h0F, 8'hF0};
        send(64'hFF80_0000_0000_0000, 64'h0102030405060708, 8'h96, 2'd0, 2'd2, 1'b1, 1'b0);
        for (int b = 0; b < 4; b++) begin
            want = {1'b1, 3'(b), b == 3, 1'b0, 2'd2, eb[b], e0[b], e1[b]};
            total++;
            if (snap() !== want) begin
                bad++; $display("FAIL x4_beat%0d got=%h want=%h", b, snap(), want);
            end else $display("x4 beat%0d ok", b);
            @(negedge clk);
        end
    endtask

    task automatic test_x8();
        snap_t want;
        logic [63:0] e0;
        logic [63:0] e1;
        logic [7:0]  beb;
        send(64'h0000_0000_0000_0080, 64'h7F00_0000_0000_0001, 8'hA5, 2'd0, 2'd3, 1'b1, 1'b1);
        beb = 8'hA5;
        for (int b = 0; b < 8; b++) begin
            e0 = (b == 0) ? 64'hFFFFFFFF_FFFFFF80 : 64'h0;
            e1 = (b == 0) ? 64'h1 : (b == 7) ? 64'h7F : 64'h0;
            want = {1'b1, 3'(b), b == 7, 1'b0, 2'd3, {8{beb[b]}}, e0, e1};
            total++;
            if (snap() !== want) begin
                bad++; $display("FAIL x8_beat%0d got=%h want=%h", b, snap(), want);
            end else $display("x8 beat%0d ok", b);
            @(negedge clk);
        end
    endtask

    task automatic test_pass();
        snap_t want;
        send(64'hDEADBEEF_CAFEF00D, 64'h0123456789ABCDEF, 8'h5A, 2'd1, 2'd0, 1'b1, 1'b1);
        want = {1'b1, 3'd0, 1'b1, 1'b0, 2'd1, 8'h5A, 64'hDEADBEEF_CAFEF00D, 64'h0123456789ABCDEF};
        total++;
        if (snap() !== want) begin
            bad++; $display("FAIL pass_beat got=%h want=%h", snap(), want);
        end else $display("pass beat0 ok");
        @(negedge clk);
    endtask

    task automatic test_err();
        snap_t want;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 8'hFF, 2'd2, 2'd2, 1'b1, 1'b0);
        for (int b = 0; b < 4; b++) begin
            want = {1'b1, 3'(b), b == 3, 1'b1, 2'd0, 8'h00, 64'h0, 64'h0};
            total++;
            if (snap() !== want) begin
                bad++; $display("FAIL err_beat%0d got=%h want=%h", b, snap(), want);
            end else $display("err beat%0d ok", b);
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e0 [4];
        logic [63:0] e1 [4];
        logic [7:0]  eb [4];
        logic [1:0]  es [4];
        snap_t want;
        int e;
        int cyc;
        e0 = '{64'h0089_00AB_00CD_00EF, 64'h0001_0023_0045_0067,
               64'h00000001_FFFFFFFF, 64'hFFFF8000_00007FFF};
        e1 = '{64'h0076_0054_0032_0010, 64'hFFFE_FFDC_FFBA_FF98,
               64'h00000001_0000FFFF, 64'h00008000_00007FFF};
        eb = '{8'h00, 8'hFF, 8'hF0, 8'h0F};
        es = '{2'd1, 2'd1, 2'd2, 2'd2};
        bus.out_ready = 1'b0;
        bus.in_vec0 = 64'h0123456789ABCDEF; bus.in_vec1 = 64'hFEDCBA9876543210;
        bus.in_be = 8'hF0; bus.in_sew = 2'd0; bus.in_factor = 2'd1;
        bus.in_signed0 = 1'b0; bus.in_signed1 = 1'b1; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_vec0 = 64'h8000_7FFF_0001_FFFF; bus.in_vec1 = 64'h8000_7FFF_0001_FFFF;
        bus.in_be = 8'h3C; bus.in_sew = 2'd1; bus.in_factor = 2'd1;
        bus.in_signed0 = 1'b1; bus.in_signed1 = 1'b0;
        e = 0;
        cyc = 0;
        while (e < 4 && cyc < 100) begin
            if (e >= 2) bus.in_valid = 1'b0;
            bus.out_ready = (cyc == 0 || cyc == 3) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            want = {1'b1, 3'(e % 2), (e % 2) == 1, 1'b0, es[e], eb[e], e0[e], e1[e]};
            total++;
            if (snap() !== want) begin
                bad++; $display("FAIL b2b_cyc%0d got=%h want=%h", cyc, snap(), want);
            end
            total++;
            if (bus.in_ready !== (bus.out_ready && (e == 1 || e == 3))) begin
                bad++; $display("FAIL b2b_in_ready_cyc%0d got=%b want=%b", cyc, bus.in_ready,
                                bus.out_ready && (e == 1 || e == 3));
            end
            $display("b2b cyc%0d seq=%0d out_ready=%b", cyc, e, bus.out_ready);
            if (bus.out_ready) e++;
            @(negedge clk);
            cyc++;
        end
        if (e < 4) begin
            total++; bad++; $display("FAIL b2b_timeout got=%0d want=4", e);
        end
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_idle got=%b/%b want=0/1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        snap_t want;
        bus.out_ready = 1'b1;
        send(64'hFF80_0000_0000_0000, 64'h0102030405060708, 8'h96, 2'd0, 2'd2, 1'b1, 1'b0);
        @(negedge clk);
        total++;
        if (bus.out_beat !== 3'd1) begin
            bad++; $display("FAIL rstmid_pre got=%0d want=1", bus.out_beat);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (snap() !== '0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_drop got=%h/%b want=0/1", snap(), bus.in_ready);
        end else $display("rstmid drop ok");
        @(negedge clk);
        rst_n = 1'b1;
        send(64'h8899AABB_00FF7F80, 64'h8899AABB_00FF7F80, 8'h05, 2'd0, 2'd1, 1'b1, 1'b0);
        want = {1'b1, 3'd0, 1'b0, 1'b0, 2'd1, 8'h33, 64'h0000_FFFF_007F_FF80, 64'h0000_00FF_007F_0080};
        total++;
        if (snap() !== want) begin
            bad++; $display("FAIL rstmid_restart got=%h want=%h", snap(), want);
        end else $display("rstmid restart ok");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_vec0 = '0; bus.in_vec1 = '0; bus.in_be = '0;
        bus.in_sew = '0; bus.in_factor = '0; bus.in_signed0 = 1'b0; bus.in_signed1 = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_x2();
        test_x4();
        test_x8();
        test_pass();
        test_err();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
